pattern_detector: RTL and testbench

- Serial bit-pattern detector with a stretched output.
- Samples the 1-bit input `sig` on every rising clock edge and compares the most recent PATTERN_LEN samples against a fixed PATTERN; overlapping matches count.
- On a match it asserts `out` for HOLD_CYCLES clock cycles, so slower downstream logic or an LED can observe the event.
- Sits between a synchronized serial input and a status indicator.

---
 rtl/pattern_detector.sv | 92 +++++++++
 tb/tb_pattern_detector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pattern_detector.sv
// Purpose: serial bit-pattern detector; a match raises 'out' for HOLD_CYCLES cycles (optional macro PATTERN_RETRIGGER_EN).
// Latency: 'out' rises on the edge that samples the final pattern bit and is a registered flag.
// Backpressure: none; 'sig' is sampled every rising edge and the hold window runs independently.
module pattern_detector #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1001,
  parameter int                     HOLD_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic out
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam int CNT_W  = $clog2(HOLD_CYCLES) + 1;
  localparam int FILL_W = $clog2(PATTERN_LEN + 1);

  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PATTERN_LEN - 1);

`ifdef PATTERN_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  // Only the newest PATTERN_LEN-1 samples need storing: the current 'sig'
  // completes the window, and the oldest sample drops out on the same edge.
  logic [PATTERN_LEN-2:0] hist;
  logic [PATTERN_LEN-1:0] window;
  logic [FILL_W-1:0]      fill;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_nxt;
  state_t                 state;
  state_t                 state_nxt;
  logic                   match;

  assign window = {hist, sig};
  // Require a full window of real samples so reset zeros never form a match.
  assign match  = (window == PATTERN) && (fill >= FILL_ARM);

  // Shift in the new sample and count samples since reset (saturating).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else begin
      hist <= window[PATTERN_LEN-2:0];
      if (fill != FILL_MAX) fill <= fill + 1'b1;
    end
  end

  // Hold-window state and countdown registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Open the window on a match, count it down, optionally re-arm on a new match.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (match) begin
          state_nxt = HOLD;
          cnt_nxt   = CNT_LOAD;
        end
      end
      HOLD: begin
        if (RETRIGGER && match) begin
          cnt_nxt = CNT_LOAD;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  assign out = (state == HOLD);

endmodule

// File: tb/tb_pattern_detector.sv
// Bench for pattern_detector: three parameterisations share one stimulus stream.
// Expected outputs come from a sample-queue reference model pushed into a scoreboard.
// A negedge monitor pops and compares; directed hold-length and async-reset checks add to it.
module tb_pattern_detector;

  localparam int N = 3;

`ifdef PATTERN_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig = 1'b0;
  logic o0, o1, o2;

  always #5 clk = ~clk;

  pattern_detector u0 (
    .clk(clk), .rst(rst), .sig(sig), .out(o0)
  );

  pattern_detector #(.PATTERN_LEN(4), .PATTERN(4'b0001), .HOLD_CYCLES(8)) u1 (
    .clk(clk), .rst(rst), .sig(sig), .out(o1)
  );

  pattern_detector #(.PATTERN_LEN(2), .PATTERN(2'b11), .HOLD_CYCLES(1)) u2 (
    .clk(clk), .rst(rst), .sig(sig), .out(o2)
  );

  int plen [N] = '{4, 4, 2};
  int pat  [N] = '{9, 1, 3};
  int hold [N] = '{16, 8, 1};

  bit             samples[$];
  int             expiry [N];
  int             hi_cnt [N];
  logic [N-1:0]   exp_q[$];
  int             cyc    = 0;
  int             errors = 0;
  int             checks = 0;

  task automatic check_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: keep the sample stream since reset; a match is the last plen
  // samples read as a binary number equal to the pattern. 'out' is high while
  // the cycle index is below the window expiry.
  task automatic model_edge();
    logic [N-1:0] e;
    int           v;
    bit           m;
    cyc++;
    e = '0;
    if (!rst) begin
      samples.delete();
      for (int i = 0; i < N; i++) expiry[i] = 0;
    end else begin
      samples.push_back(sig);
      if (samples.size() > 16) void'(samples.pop_front());
      for (int i = 0; i < N; i++) begin
        m = 1'b0;
        if (samples.size() >= plen[i]) begin
          v = 0;
          for (int j = samples.size() - plen[i]; j < samples.size(); j++)
            v = (v << 1) | int'(samples[j]);
          m = (v == pat[i]);
        end
        if (m && (RETRIG || (cyc - 1 >= expiry[i]))) expiry[i] = cyc + hold[i];
        e[i] = (cyc < expiry[i]);
      end
    end
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive after the negedge, let the model follow the posedge.
  task automatic tick(input bit b, input bit r);
    logic [N-1:0] cur;
    @(negedge clk);
    #1;
    if (rst && !r) begin
      rst = 1'b0;
      sig = b;
      #1;
      cur = {o2, o1, o0};
      for (int i = 0; i < N; i++) check_bit($sformatf("async_reset_u%0d", i), cur[i], 1'b0);
    end else begin
      rst = r;
      sig = b;
    end
    @(posedge clk);
    model_edge();
  endtask

  task automatic play(input logic [31:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) tick(bits[k], 1'b1);
  endtask

  task automatic clear_hi();
    for (int i = 0; i < N; i++) hi_cnt[i] = 0;
  endtask

  // Scoreboard monitor: compare every cycle against the queued expectation.
  always @(negedge clk) begin
    logic [N-1:0] e;
    logic [N-1:0] cur;
    if (exp_q.size() != 0) begin
      e   = exp_q.pop_front();
      cur = {o2, o1, o0};
      for (int i = 0; i < N; i++) begin
        check_bit($sformatf("out_u%0d", i), cur[i], e[i]);
        if (cur[i] === 1'b1) hi_cnt[i]++;
      end
    end
  end

  initial begin
    clear_hi();

    // Reset then idle.
    tick(1'b0, 1'b0);
    repeat (20) tick(1'b0, 1'b1);

    // Basic isolated match on the default instance.
    clear_hi();
    play(32'b1001, 4);
    repeat (30) tick(1'b0, 1'b1);
    check_int("basic_hold_len_u0", hi_cnt[0], 16);

    // Overlap and near-misses.
    tick(1'b0, 1'b0);
    clear_hi();
    play(32'b1010011001010, 13);
    repeat (30) tick(1'b0, 1'b1);
    check_int("overlap_hold_len_u0", hi_cnt[0], RETRIG ? 20 : 16);

    // No false match from reset zeros (pattern 0001).
    tick(1'b0, 1'b0);
    clear_hi();
    play(32'b10001, 5);
    repeat (12) tick(1'b0, 1'b1);
    check_int("no_false_match_u1", hi_cnt[1], 8);

    // Asynchronous reset in the middle of a hold window.
    play(32'b1001, 4);
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    play(32'b001, 3);
    repeat (20) tick(1'b0, 1'b1);

    // Retrigger split: matches five cycles apart, HOLD_CYCLES=8.
    tick(1'b0, 1'b0);
    clear_hi();
    play(32'b000100001, 9);
    repeat (20) tick(1'b0, 1'b1);
    check_int("retrigger_hold_len_u1", hi_cnt[1], RETRIG ? 13 : 8);

    // Randomized stream with occasional resets.
    for (int k = 0; k < 3000; k++)
      tick(1'($urandom_range(0, 1)), ($urandom_range(0, 249) != 0));

    repeat (20) tick(1'b0, 1'b1);
    @(negedge clk);
    #2;
    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
